// File: rtl/linked_list_sched.sv
// Push/pop scheduler for the shared linked_list_fifo: round-robin producer
// arbitration with a per-queue quota, and round-robin drain into one registered output.
module linked_list_sched #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter int NUM_FIFOS = 2,
    parameter int QUOTA     = DEPTH,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_FIFOS-1:0]       in_valid,
    input  logic [NUM_FIFOS*WIDTH-1:0] in_data,
    output logic [NUM_FIFOS-1:0]       in_ready,
    output logic                       ff_push,
    output logic [SEL_WIDTH-1:0]       ff_push_sel,
    output logic [WIDTH-1:0]           ff_data_in,
    output logic                       ff_pop,
    output logic [SEL_WIDTH-1:0]       ff_pop_sel,
    input  logic                       ff_full,
    input  logic [NUM_FIFOS-1:0]       ff_empty,
    input  logic [WIDTH-1:0]           ff_data_out,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [SEL_WIDTH-1:0]       out_sel,
    input  logic                       out_ready
);

    localparam logic [PTR_WIDTH:0] QUOTA_C = QUOTA[PTR_WIDTH:0];

    logic [SEL_WIDTH-1:0] push_rr;
    logic [SEL_WIDTH-1:0] pop_rr;
    logic [PTR_WIDTH:0]   occ [NUM_FIFOS];

    logic [NUM_FIFOS-1:0] push_elig;
    logic [NUM_FIFOS-1:0] pop_elig;
    logic [NUM_FIFOS-1:0] pop_to;
    logic                 slot_free;
    logic                 push_hit;
    logic                 pop_hit;
    logic [SEL_WIDTH-1:0] push_g;
    logic [SEL_WIDTH-1:0] pop_g;

    function automatic logic [SEL_WIDTH-1:0] rr_idx(input logic [SEL_WIDTH-1:0] base,
                                                    input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_FIFOS) sum = sum - NUM_FIFOS;
        return sum[SEL_WIDTH-1:0];
    endfunction

    // Returns {found, index} of the first eligible queue starting at base.
    function automatic logic [SEL_WIDTH:0] rr_pick(input logic [NUM_FIFOS-1:0] elig,
                                                   input logic [SEL_WIDTH-1:0] base);
        logic [SEL_WIDTH:0]   result;
        logic [SEL_WIDTH-1:0] idx;
        result = '0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            idx = rr_idx(base, k);
            if (!result[SEL_WIDTH] && elig[idx]) result = {1'b1, idx};
        end
        return result;
    endfunction

    always_comb begin
        slot_free = ~out_valid | out_ready;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            push_elig[i] = rst_n & in_valid[i] & (occ[i] < QUOTA_C) & ~ff_full;
            pop_elig[i]  = rst_n & ~ff_empty[i] & slot_free;
        end
        {push_hit, push_g} = rr_pick(push_elig, push_rr);
        {pop_hit, pop_g}   = rr_pick(pop_elig, pop_rr);
    end

    // NOTE: every output gets a default before the conditional overrides, so no latch is inferred.
    always_comb begin
        in_ready    = '0;
        pop_to      = '0;
        ff_push     = push_hit;
        ff_push_sel = '0;
        ff_data_in  = '0;
        ff_pop      = pop_hit;
        ff_pop_sel  = '0;
        if (push_hit) begin
            in_ready[push_g] = 1'b1;
            ff_push_sel      = push_g;
            ff_data_in       = in_data[int'(push_g)*WIDTH +: WIDTH];
        end
        if (pop_hit) begin
            pop_to[pop_g] = 1'b1;
            ff_pop_sel    = pop_g;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_rr   <= '0;
            pop_rr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            // NOTE: occ is a handful of counters, not a RAM, so it is cleared element by element.
            for (int i = 0; i < NUM_FIFOS; i++) occ[i] <= '0;
        end else begin
            if (push_hit) push_rr <= rr_idx(push_g, 1);

            if (pop_hit) begin
                pop_rr    <= rr_idx(pop_g, 1);
                out_valid <= 1'b1;
                out_data  <= ff_data_out;
                out_sel   <= pop_g;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (in_ready[i] && !pop_to[i])      occ[i] <= occ[i] + 1'b1;
                else if (pop_to[i] && !in_ready[i]) occ[i] <= occ[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_linked_list_sched.sv
// Bench for linked_list_sched: behavioural shared-FIFO model, per-queue data
// scoreboard, a cycle table for fairness/full/drain, and hand sequences for corner cases.
module tb_linked_list_sched;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int NF    = 2;
    localparam int QUOTA = 2;

    logic             clk;
    logic             rst_n;
    logic [NF-1:0]    in_valid;
    logic [NF*WIDTH-1:0] in_data;
    logic [NF-1:0]    in_ready;
    logic             ff_push;
    logic             ff_push_sel;
    logic [WIDTH-1:0] ff_data_in;
    logic             ff_pop;
    logic             ff_pop_sel;
    logic             ff_full;
    logic [NF-1:0]    ff_empty;
    logic [WIDTH-1:0] ff_data_out;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    linked_list_sched #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NF), .QUOTA(QUOTA)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ff_push(ff_push), .ff_push_sel(ff_push_sel), .ff_data_in(ff_data_in),
        .ff_pop(ff_pop), .ff_pop_sel(ff_pop_sel),
        .ff_full(ff_full), .ff_empty(ff_empty), .ff_data_out(ff_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared FIFO model: per-queue ring, status registered, head word combinational.
    logic [WIDTH-1:0] fmem [NF][4];
    logic [1:0]       fhead [NF];
    logic [2:0]       fcnt [NF];
    logic             cap_push, cap_psel, cap_pop, cap_popsel;
    logic [WIDTH-1:0] cap_din;

    assign ff_full     = (fcnt[0] + fcnt[1]) == 3'd4;
    assign ff_empty    = {fcnt[1] == 3'd0, fcnt[0] == 3'd0};
    assign ff_data_out = fmem[ff_pop_sel][fhead[ff_pop_sel]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NF; q++) begin
                fhead[q] <= 2'd0;
                fcnt[q]  <= 3'd0;
            end
        end else begin
            for (int q = 0; q < NF; q++) begin
                if (cap_push && cap_psel == 1'(q))
                    fmem[q][fhead[q] + fcnt[q][1:0]] <= cap_din;
                if (cap_pop && cap_popsel == 1'(q))
                    fhead[q] <= fhead[q] + 2'd1;
                if ((cap_push && cap_psel == 1'(q)) && !(cap_pop && cap_popsel == 1'(q)))
                    fcnt[q] <= fcnt[q] + 3'd1;
                else if ((cap_pop && cap_popsel == 1'(q)) && !(cap_push && cap_psel == 1'(q)))
                    fcnt[q] <= fcnt[q] - 3'd1;
            end
        end
    end

    logic [WIDTH-1:0] sb0 [$];
    logic [WIDTH-1:0] sb1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called once per cycle at the negedge: feeds the FIFO model and the scoreboard.
    task automatic monitor();
        logic [WIDTH-1:0] w;
        cap_push   = ff_push;
        cap_psel   = ff_push_sel;
        cap_din    = ff_data_in;
        cap_pop    = ff_pop;
        cap_popsel = ff_pop_sel;
        if (!rst_n) return;
        check("ready_matches_push", 32'(|in_ready), 32'(ff_push));
        if (ff_push) check("push_while_full", ff_full, 1'b0);
        if (ff_pop)  check("pop_from_empty", ff_empty[ff_pop_sel], 1'b0);
        if (in_valid[0] && in_ready[0]) sb0.push_back(in_data[3:0]);
        if (in_valid[1] && in_ready[1]) sb1.push_back(in_data[7:4]);
        if (out_valid && out_ready) begin
            if (out_sel == 1'b0) begin
                check("sb0_has_word", 32'(sb0.size() != 0), 1'b1);
                if (sb0.size() != 0) begin
                    w = sb0.pop_front();
                    check("out_data_q0", out_data, w);
                end
            end else begin
                check("sb1_has_word", 32'(sb1.size() != 0), 1'b1);
                if (sb1.size() != 0) begin
                    w = sb1.pop_front();
                    check("out_data_q1", out_data, w);
                end
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    typedef struct {
        logic [1:0] iv;
        logic [7:0] data;
        logic       ordy;
        logic [1:0] irdy;
        logic       push;
        logic       psel;
        logic [3:0] din;
        logic       pop;
        logic       popsel;
        logic       ov;
        logic [3:0] od;
        logic       osel;
    } vec_t;

    vec_t vt [13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       done;
        logic [3:0] c_od   [5];
        logic       c_osel [5];
        logic       c_ov   [5];
        logic       c_pop  [5];
        logic       c_psel [5];

        // Both producers streaming, consumer stalled, then draining.
        //          iv     data   ordy  irdy  push psel din   pop  psel ov   od    osel
        vt[0]  = '{2'b11, 8'h91, 1'b0, 2'b01, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
        vt[1]  = '{2'b11, 8'h92, 1'b0, 2'b10, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vt[2]  = '{2'b11, 8'hA2, 1'b0, 2'b01, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vt[3]  = '{2'b11, 8'hA3, 1'b0, 2'b10, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vt[4]  = '{2'b11, 8'hB3, 1'b0, 2'b01, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vt[5]  = '{2'b11, 8'hB4, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vt[6]  = '{2'b11, 8'hB4, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0};
        vt[7]  = '{2'b11, 8'hB4, 1'b1, 2'b10, 1'b1, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 4'h9, 1'b1};
        vt[8]  = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0};
        vt[9]  = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1};
        vt[10] = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0};
        vt[11] = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1};
        vt[12] = '{2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};

        // Reset with both producers valid and the consumer ready.
        rst_n = 1'b0;
        drive(2'b11, 8'h91, 1'b1);
        repeat (2) begin
            to_neg();
            check("rst_in_ready", in_ready, 2'b00);
            check("rst_ff_push", ff_push, 1'b0);
            check("rst_ff_pop", ff_pop, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            to_pos();
        end
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].iv, vt[i].data, vt[i].ordy);
            to_neg();
            check($sformatf("row%0d_in_ready", i), in_ready, vt[i].irdy);
            check($sformatf("row%0d_ff_push", i), ff_push, vt[i].push);
            check($sformatf("row%0d_push_sel", i), ff_push_sel, vt[i].psel);
            if (vt[i].push) check($sformatf("row%0d_data_in", i), ff_data_in, vt[i].din);
            check($sformatf("row%0d_ff_pop", i), ff_pop, vt[i].pop);
            check($sformatf("row%0d_pop_sel", i), ff_pop_sel, vt[i].popsel);
            check($sformatf("row%0d_out_valid", i), out_valid, vt[i].ov);
            if (vt[i].ov) begin
                check($sformatf("row%0d_out_data", i), out_data, vt[i].od);
                check($sformatf("row%0d_out_sel", i), out_sel, vt[i].osel);
            end
            to_pos();
        end

        // Quota, simultaneous push/pop on queue 0, and backpressure.
        drive(2'b01, 8'h05, 1'b0);
        to_neg();
        check("quota_c0_in_ready", in_ready, 2'b01);
        check("quota_c0_ff_pop", ff_pop, 1'b0);
        to_pos();
        drive(2'b01, 8'h06, 1'b0);
        to_neg();
        check("simul_ff_push", ff_push, 1'b1);
        check("simul_push_sel", ff_push_sel, 1'b0);
        check("simul_ff_pop", ff_pop, 1'b1);
        check("simul_pop_sel", ff_pop_sel, 1'b0);
        check("simul_ff_full", ff_full, 1'b0);
        to_pos();
        drive(2'b01, 8'h07, 1'b0);
        to_neg();
        check("quota_occ1_in_ready", in_ready, 2'b01);
        to_pos();
        drive(2'b01, 8'h08, 1'b0);
        for (int k = 0; k < 3; k++) begin
            to_neg();
            check($sformatf("quota_block%0d_in_ready", k), in_ready, 2'b00);
            check($sformatf("quota_block%0d_ff_full", k), ff_full, 1'b0);
            check($sformatf("bp%0d_ff_pop", k), ff_pop, 1'b0);
            check($sformatf("bp%0d_out_valid", k), out_valid, 1'b1);
            check($sformatf("bp%0d_out_data", k), out_data, 4'h5);
            to_pos();
        end
        out_ready = 1'b1;
        to_neg();
        check("bp_release_ff_pop", ff_pop, 1'b1);
        check("bp_release_pop_sel", ff_pop_sel, 1'b0);
        check("bp_release_in_ready", in_ready, 2'b00);
        to_pos();
        out_ready = 1'b0;
        to_neg();
        check("quota_reopen_in_ready", in_ready, 2'b01);
        to_pos();
        drive(2'b00, 8'h00, 1'b1);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            to_neg();
            if (!out_valid) done = 1'b1;
            else to_pos();
        end
        check("quota_drain_done", out_valid, 1'b0);
        if (done) to_pos();

        // Drain order: filler E held in the output, then {0:C,D} {1:5}.
        drive(2'b10, 8'hE0, 1'b0);
        to_neg();
        check("load_e_in_ready", in_ready, 2'b10);
        to_pos();
        drive(2'b01, 8'h0C, 1'b0);
        to_neg();
        check("load_x_in_ready", in_ready, 2'b01);
        check("load_x_ff_pop", ff_pop, 1'b1);
        check("load_x_pop_sel", ff_pop_sel, 1'b1);
        to_pos();
        drive(2'b01, 8'h0D, 1'b0);
        to_neg();
        check("load_y_in_ready", in_ready, 2'b01);
        check("load_y_ff_pop", ff_pop, 1'b0);
        to_pos();
        drive(2'b10, 8'h50, 1'b0);
        to_neg();
        check("load_z_in_ready", in_ready, 2'b10);
        to_pos();
        c_ov   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        c_od   = '{4'hE, 4'hC, 4'h5, 4'hD, 4'h0};
        c_osel = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        c_pop  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        c_psel = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(2'b00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            to_neg();
            check($sformatf("order%0d_out_valid", k), out_valid, c_ov[k]);
            if (c_ov[k]) begin
                check($sformatf("order%0d_out_data", k), out_data, c_od[k]);
                check($sformatf("order%0d_out_sel", k), out_sel, c_osel[k]);
            end
            check($sformatf("order%0d_ff_pop", k), ff_pop, c_pop[k]);
            check($sformatf("order%0d_pop_sel", k), ff_pop_sel, c_psel[k]);
            to_pos();
        end
        check("sb0_empty", sb0.size(), 0);
        check("sb1_empty", sb1.size(), 0);

        // Reset while a word sits in the output register.
        drive(2'b01, 8'h0F, 1'b0);
        to_neg();
        check("midrst_push_in_ready", in_ready, 2'b01);
        to_pos();
        drive(2'b00, 8'h00, 1'b0);
        to_neg();
        to_pos();
        to_neg();
        check("midrst_pre_out_valid", out_valid, 1'b1);
        check("midrst_pre_out_data", out_data, 4'hF);
        #2;
        drive(2'b11, 8'hFF, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 4'h0);
        check("midrst_in_ready", in_ready, 2'b00);
        check("midrst_ff_push", ff_push, 1'b0);
        sb0.delete();
        sb1.delete();
        to_pos();
        rst_n = 1'b1;
        drive(2'b00, 8'h00, 1'b0);
        to_neg();
        check("postrst_out_valid", out_valid, 1'b0);
        check("postrst_ff_pop", ff_pop, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/linked_list_sched.md
# linked_list_sched

Request scheduler for the shared `linked_list_fifo`. It arbitrates up to NUM_FIFOS producer streams onto the FIFO's single push port, enforcing a per-queue occupancy quota. It also drains the logical queues round-robin through the single pop port into one registered valid/ready consumer port. It sits between the producer/consumer clients and `linked_list_fifo`, and is the only block that drives that FIFO's push/pop controls.

## Interface
- WIDTH, 4, data word width
- DEPTH, 2, shared FIFO entries (power of two, ≥2)
- NUM_FIFOS, 2, logical queues (≥2)
- QUOTA, DEPTH, max entries one queue may hold (1..DEPTH)
- SEL_WIDTH, $clog2(NUM_FIFOS), queue select width
- PTR_WIDTH, $clog2(DEPTH), FIFO pointer width

Ports:
- clk  in  1  the single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_FIFOS  producer i has a word
- in_data  in  NUM_FIFOS*WIDTH  producer i word at [i*WIDTH +: WIDTH]
- in_ready  out  NUM_FIFOS  one-hot grant; word i accepted when in_valid[i]&in_ready[i]
- ff_push  out  1  to FIFO push
- ff_push_sel  out  SEL_WIDTH  to FIFO push_sel
- ff_data_in  out  WIDTH  to FIFO data_in
- ff_pop  out  1  to FIFO pop
- ff_pop_sel  out  SEL_WIDTH  to FIFO pop_sel
- ff_full  in  1  FIFO full
- ff_empty  in  NUM_FIFOS  FIFO per-queue empty
- ff_data_out  in  WIDTH  head word of ff_pop_sel; valid in the same cycle as ff_pop
- out_valid  out  1  registered consumer valid
- out_data  out  WIDTH  registered popped word
- out_sel  out  SEL_WIDTH  queue the word came from
- out_ready  in  1  consumer accepts

## Operation
- State:
  - push_rr, pop_rr (SEL_WIDTH): round-robin pointers
  - occ[i] (PTR_WIDTH+1 bits): per-queue occupancy
  - out register: out_valid, out_data, out_sel
- Push eligibility: queue i is eligible when in_valid[i] & (occ[i] < QUOTA) & ~ff_full.
- Push grant:
  - Grant the first eligible index scanning push_rr, push_rr+1, … modulo NUM_FIFOS.
  - On grant g: in_ready[g]=1; ff_push=1; ff_push_sel=g; ff_data_in=in_data[g].
  - Next push_rr = (g+1) mod NUM_FIFOS. With no grant, push_rr holds.
- Pop eligibility: slot_free = ~out_valid | out_ready. Queue i is eligible when ~ff_empty[i] & slot_free.
- Pop grant:
  - Grant the first eligible index from pop_rr. On grant p: ff_pop=1; ff_pop_sel=p.
  - Load out_data←ff_data_out, out_sel←p, out_valid←1.
  - Next pop_rr = (p+1) mod NUM_FIFOS.
- Output register without a pop: if out_valid & out_ready, out_valid←0 (out_data and out_sel hold).
- Occupancy: occ[i] ← occ[i] + (push to i) − (pop from i). Push and pop of the same queue in one cycle leaves occ unchanged.
- Output rules:
  - At most one push and one pop per cycle; push and pop in the same cycle are allowed, including to the same queue.
  - ff_push is never asserted while ff_full. ff_pop is never asserted for an empty queue.
  - ff_push_sel/ff_pop_sel are 0 when the corresponding strobe is 0.
- Reset (rst_n=0, asynchronous):
  - Registers clear: out_valid=0, out_data=0, out_sel=0, pointers=0, occ=0.
  - All combinational grants (in_ready, ff_push, ff_pop) are forced 0 while rst_n=0.
  - A reset mid-transfer drops the output word; the FIFO is reset on the same rst.

## Timing
- Push path is combinational: in_valid → in_ready/ff_push in the same cycle; the word commits at the next posedge.
- Pop path: ff_pop is combinational from registered state, out_ready and ff_empty. The word appears on out_data one cycle after ff_pop. Consumer throughput is 1 word/cycle when out_ready=1 continuously.
- ff_empty/ff_full are the FIFO's registered status. A word pushed to an empty queue is first poppable the cycle after the push.
- No combinational path from in_valid to ff_pop or from out_ready to in_ready.

## Test plan
- Reset: hold rst_n=0 with in_valid=2'b11 and out_ready=1 → in_ready=0, ff_push=0, ff_pop=0, out_valid=0. Release → first push grants queue 0.
- Push fairness: NUM_FIFOS=2, DEPTH=4, QUOTA=4, both producers valid continuously with data A0,A1…/B0,B1… and out_ready=0 → grants alternate 0,1,0,1. After 4 pushes ff_full=1 and in_ready=0 from then on.
- Quota: QUOTA=2, only producer 0 valid → 2 pushes, then in_ready[0]=0 while occ[0]=2. A single pop from queue 0 makes it eligible again the next cycle.
- Drain order: queues hold {0:X,Y} and {1:Z} with out_ready=1 → out_data sequence X(sel0), Z(sel1), Y(sel0), one word/cycle, then out_valid=0.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles → ff_pop=0 and out_data stable. Raising out_ready gives a pop in that same cycle.
- Simultaneous push/pop to queue 0 with ff_full=0 → ff_push and ff_pop both 1 and occ[0] unchanged.
